game_flow_ctl: RTL and testbench

GAME_FLOW_CTL -- requirements
Module: game_flow_ctl

---
 rtl/game_flow_ctl.sv | 121 ++++++++++++
 tb/tb_game_flow_ctl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/game_flow_ctl.sv
// game_flow_ctl: match sequencing for the pong game -- idle, 3-2-1 countdown, play,
// post-goal pause and game over, with registered control outputs for the ball controller.
module game_flow_ctl #(
   parameter int WIN_SCORE    = 7,
   parameter int COUNT_FRAMES = 60,
   parameter int GOAL_FRAMES  = 90
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic       frame_tick,
   input  logic [3:0] player_1_score,
   input  logic [3:0] player_2_score,
   output logic       ball_run,
   output logic       ball_hold,
   output logic       score_clear,
   output logic [2:0] game_state,
   output logic [1:0] countdown,
   output logic [1:0] winner
);
   typedef enum logic [2:0] {IDLE = 3'd0, CNTDN = 3'd1, PLAY = 3'd2, GOAL = 3'd3, OVER = 3'd4} state_t;
   localparam logic [3:0] WS = 4'(WIN_SCORE);
   localparam logic [7:0] CF = 8'(COUNT_FRAMES);
   localparam logic [7:0] GF = 8'(GOAL_FRAMES);
   state_t     state_q, state_d;
   logic [7:0] fcnt_q, fcnt_d, fcnt_inc;
   logic [1:0] cd_q, cd_d, win_q, win_d;
   logic [3:0] sh1_q, sh2_q;
   logic       clr_q, clr_d, run_q, hold_q, btn_q, armed_q;
   logic       start_edge, score_chg;
   // armed_q stays low until the button has been seen released after reset
   assign start_edge = start_btn & ~btn_q & armed_q;
   assign score_chg  = (player_1_score != sh1_q) | (player_2_score != sh2_q);
   assign fcnt_inc   = fcnt_q + 8'd1;
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      cd_d    = cd_q;
      win_d   = win_q;
      clr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            fcnt_d = 8'd0;
            win_d  = 2'd0;
            if (start_edge) begin
               state_d = CNTDN;
               cd_d    = 2'd3;
               clr_d   = 1'b1;
            end
         end
         CNTDN: if (frame_tick) begin
            fcnt_d = (fcnt_inc == CF) ? 8'd0 : fcnt_inc;
            if (fcnt_inc == CF) begin
               cd_d    = cd_q - 2'd1;
               state_d = (cd_q == 2'd1) ? PLAY : CNTDN;
            end
         end
         PLAY: begin
            fcnt_d = 8'd0;
            cd_d   = 2'd0;
            if (score_chg) begin
               state_d = (player_1_score >= WS || player_2_score >= WS) ? OVER : GOAL;
               win_d   = (player_1_score >= WS) ? 2'd1 : (player_2_score >= WS) ? 2'd2 : 2'd0;
            end
         end
         GOAL: if (frame_tick) begin
            fcnt_d = (fcnt_inc == GF) ? 8'd0 : fcnt_inc;
            if (fcnt_inc == GF) begin
               state_d = CNTDN;
               cd_d    = 2'd3;
            end
         end
         OVER: begin
            fcnt_d = 8'd0;
            if (start_edge) begin
               state_d = IDLE;
               win_d   = 2'd0;
            end
         end
         default: begin
            state_d = IDLE;
            fcnt_d  = 8'd0;
            win_d   = 2'd0;
         end
      endcase
   end
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         fcnt_q  <= 8'd0;
         cd_q    <= 2'd0;
         win_q   <= 2'd0;
         clr_q   <= 1'b0;
         run_q   <= 1'b0;
         hold_q  <= 1'b1;
         btn_q   <= 1'b0;
         armed_q <= 1'b0;
         sh1_q   <= 4'd0;
         sh2_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         cd_q    <= cd_d;
         win_q   <= win_d;
         clr_q   <= clr_d;
         run_q   <= state_d == PLAY;
         hold_q  <= state_d != PLAY;
         btn_q   <= start_btn;
         armed_q <= armed_q | ~start_btn;
         // zeroing while the clear pulse is out hides the downstream reset from change detection
         sh1_q   <= clr_q ? 4'd0 : player_1_score;
         sh2_q   <= clr_q ? 4'd0 : player_2_score;
      end
   end
   assign ball_run    = run_q;
   assign ball_hold   = hold_q;
   assign score_clear = clr_q;
   assign game_state  = state_q;
   assign countdown   = cd_q;
   assign winner      = win_q;
endmodule

// File: tb/tb_game_flow_ctl.sv
// tb_game_flow_ctl: directed vector table, hand sequences and random stimulus
// checked against a tick-counting behavioural model of the match flow.
module tb_game_flow_ctl;
   localparam int CF = 2, GF = 3, WS = 2;
   logic       clk = 1'b0, rst_n = 1'b0, btn = 1'b0, tick = 1'b0;
   logic [3:0] p1 = 4'd0, p2 = 4'd0;
   logic       ball_run, ball_hold, score_clear;
   logic [2:0] game_state;
   logic [1:0] countdown, winner;
   int         checks = 0, passed = 0;
   game_flow_ctl #(.WIN_SCORE(WS), .COUNT_FRAMES(CF), .GOAL_FRAMES(GF)) dut (
      .clk_in(clk), .rst_n(rst_n), .start_btn(btn), .frame_tick(tick),
      .player_1_score(p1), .player_2_score(p2), .ball_run(ball_run), .ball_hold(ball_hold),
      .score_clear(score_clear), .game_state(game_state), .countdown(countdown), .winner(winner));
   always #5 clk = ~clk;
   typedef struct {
      logic b, t; logic [3:0] a, c;
      logic [2:0] st; logic [1:0] cd; logic run, clr; logic [1:0] win;
   } vec_t;
   vec_t tbl[$];
   // model: mode, elapsed ticks within the timed phase, shadows, button history
   int m_st, m_ticks, m_win, sh1, sh2;
   bit m_clr, m_prevlow;
   function automatic vec_t mk(logic b, logic t, logic [3:0] a, logic [3:0] c,
                               logic [2:0] st, logic [1:0] cd, logic run, logic clr, logic [1:0] win);
      vec_t v;
      v.b = b; v.t = t; v.a = a; v.c = c; v.st = st; v.cd = cd; v.run = run; v.clr = clr; v.win = win;
      return v;
   endfunction
   task automatic check(string name, logic [2:0] st, logic [1:0] cd, logic run, logic clr, logic [1:0] win);
      checks++;
      if ({game_state, countdown, ball_run, ball_hold, score_clear, winner} === {st, cd, run, ~run, clr, win})
         passed++;
      else
         $display("FAIL %s: got st=%0d cd=%0d run=%0b hold=%0b clr=%0b win=%0d, expected st=%0d cd=%0d run=%0b hold=%0b clr=%0b win=%0d",
                  name, game_state, countdown, ball_run, ball_hold, score_clear, winner, st, cd, run, ~run, clr, win);
   endtask
   function automatic void model_reset();
      m_st = 0; m_ticks = 0; m_win = 0; sh1 = 0; sh2 = 0; m_clr = 0; m_prevlow = 0;
   endfunction
   function automatic void model_step(bit b, bit t, int a, int c);
      bit e = b && m_prevlow;
      bit nclr = 0;
      case (m_st)
         0: if (e) begin m_st = 1; m_ticks = 0; nclr = 1; end
         1: if (t) begin m_ticks++; if (m_ticks == 3 * CF) m_st = 2; end
         2: if (a != sh1 || c != sh2) begin
               if (a >= WS) begin m_st = 4; m_win = 1; end
               else if (c >= WS) begin m_st = 4; m_win = 2; end
               else begin m_st = 3; m_ticks = 0; end
            end
         3: if (t) begin m_ticks++; if (m_ticks == GF) begin m_st = 1; m_ticks = 0; end end
         4: if (e) begin m_st = 0; m_win = 0; end
         default: m_st = 0;
      endcase
      sh1 = m_clr ? 0 : a;
      sh2 = m_clr ? 0 : c;
      m_clr = nclr;
      m_prevlow = !b;
   endfunction
   task automatic cyc(bit b, bit t, int a, int c, string name);
      btn = b; tick = t; p1 = a[3:0]; p2 = c[3:0];
      model_step(b, t, a, c);
      @(posedge clk);
      @(negedge clk);
      check(name, 3'(m_st), (m_st == 1) ? 2'(3 - m_ticks / CF) : 2'd0, m_st == 2, m_clr, 2'(m_win));
   endtask
   task automatic do_reset(bit b);
      rst_n = 1'b0; btn = b; tick = 1'b0;
      #1 check("reset_async", 3'd0, 2'd0, 1'b0, 1'b0, 2'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      int a = 0, c = 0;
      // {btn, tick, p1, p2} -> {state, countdown, run, clear, winner}
      tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0, 1,3,0,1,0));
      tbl.push_back(mk(1,0,0,0, 1,3,0,0,0));
      tbl.push_back(mk(0,1,0,0, 1,3,0,0,0));
      tbl.push_back(mk(0,1,0,0, 1,2,0,0,0));
      tbl.push_back(mk(1,1,0,0, 1,2,0,0,0));
      tbl.push_back(mk(0,1,0,0, 1,1,0,0,0));
      tbl.push_back(mk(0,0,0,0, 1,1,0,0,0));
      tbl.push_back(mk(0,1,0,0, 1,1,0,0,0));
      tbl.push_back(mk(0,1,0,0, 2,0,1,0,0));
      tbl.push_back(mk(0,1,0,0, 2,0,1,0,0));
      tbl.push_back(mk(0,0,1,0, 3,0,0,0,0));
      tbl.push_back(mk(0,1,1,0, 3,0,0,0,0));
      tbl.push_back(mk(1,1,1,0, 3,0,0,0,0));
      tbl.push_back(mk(0,1,1,0, 1,3,0,0,0));
      tbl.push_back(mk(0,1,1,1, 1,3,0,0,0));
      tbl.push_back(mk(0,1,1,1, 1,2,0,0,0));
      tbl.push_back(mk(0,1,1,1, 1,2,0,0,0));
      tbl.push_back(mk(0,1,1,1, 1,1,0,0,0));
      tbl.push_back(mk(0,1,1,1, 1,1,0,0,0));
      tbl.push_back(mk(0,1,1,1, 2,0,1,0,0));
      tbl.push_back(mk(0,0,1,1, 2,0,1,0,0));
      tbl.push_back(mk(0,0,1,2, 4,0,0,0,2));
      tbl.push_back(mk(0,1,1,2, 4,0,0,0,2));
      tbl.push_back(mk(1,0,1,2, 0,0,0,0,0));
      tbl.push_back(mk(0,0,1,0, 0,0,0,0,0));
      @(negedge clk);
      @(negedge clk);
      check("reset_state", 3'd0, 2'd0, 1'b0, 1'b0, 2'd0);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         btn = tbl[i].b; tick = tbl[i].t; p1 = tbl[i].a; p2 = tbl[i].c;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), tbl[i].st, tbl[i].cd, tbl[i].run, tbl[i].clr, tbl[i].win);
      end
      // both scores reach the limit together: player 1 wins
      do_reset(1'b0);
      cyc(0, 0, 0, 0, "both_idle");
      cyc(1, 0, 0, 0, "both_start");
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, "both_cd");
      cyc(0, 0, 1, 1, "both_play");
      cyc(0, 0, 2, 2, "both_win");
      checks++;
      if (winner === 2'd1) passed++;
      else $display("FAIL both_winner: got %0d, expected 1", winner);
      // reset mid-countdown with the button held high through release
      cyc(0, 0, 0, 0, "rst_idle");
      cyc(1, 0, 0, 0, "rst_start");
      cyc(1, 1, 0, 0, "rst_cd");
      do_reset(1'b1);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, "rst_held");
      cyc(0, 0, 0, 0, "rst_low");
      cyc(1, 0, 0, 0, "rst_restart");
      do_reset(1'b0);
      a = 0; c = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 700 == 699) begin
            do_reset(1'($urandom % 2));
            a = 0; c = 0;
         end
         if (m_clr) begin a = 0; c = 0; end
         else begin
            if ($urandom % 8 == 0 && a < 15) a++;
            if ($urandom % 8 == 0 && c < 15) c++;
         end
         cyc(($urandom % 6) == 0, 1'($urandom % 2), a, c, "random");
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
